// File: rtl/ifetch_ctrl.sv
// Fetch sequencer for a synchronous instruction memory: owns the fetch PC, tracks which PC
// the memory output belongs to, and hands instructions to decode over a valid/ready handshake.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_stall,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] instr_cnt,
    output logic [31:0] bubble_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r;
    logic [31:0] pc_f_r;
    logic        resp_valid_r;
    logic [31:0] resp_pc_r;
    logic [31:0] instr_cnt_r;
    logic [31:0] bubble_cnt_r;
    logic        id_valid_s;
    logic        stall_s;

    // Handshake view of the response; a redirect squashes whatever is being shown this cycle.
    always_comb begin
        id_valid_s = resp_valid_r & ~redirect_valid;
        stall_s    = resp_valid_r & ~id_ready & ~redirect_valid;
        if (id_valid_s) begin
            id_instr = imem_data;
        end else begin
            id_instr = NOP_INSTR;
        end
    end

    assign id_valid   = id_valid_s;
    assign imem_stall = stall_s;
    assign imem_addr  = pc_f_r;
    assign id_pc      = resp_pc_r;
    assign instr_cnt  = instr_cnt_r;
    assign bubble_cnt = bubble_cnt_r;

    // Fetch PC, response tracking, run/idle control and delivery counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_r       <= RESET_PC;
            resp_valid_r <= 1'b0;
            resp_pc_r    <= RESET_PC;
            state_r      <= IDLE;
            instr_cnt_r  <= 32'd0;
            bubble_cnt_r <= 32'd0;
        end else begin
            if (id_valid_s && id_ready) begin
                instr_cnt_r <= instr_cnt_r + 32'd1;
            end
            if ((state_r == RUN) && !id_valid_s) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end

            if (redirect_valid) begin
                pc_f_r       <= {redirect_pc[31:2], 2'b00};
                resp_valid_r <= 1'b0;
            end else if (stall_s) begin
                // imem holds its output too, so the held word and resp_pc_r stay paired
                pc_f_r       <= pc_f_r;
                resp_valid_r <= resp_valid_r;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (fetch_en) begin
                            state_r <= RUN;
                        end
                    end
                    RUN: begin
                        if (!fetch_en) begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase

                if ((state_r == RUN) && fetch_en) begin
                    resp_pc_r    <= pc_f_r;
                    resp_valid_r <= 1'b1;
                    pc_f_r       <= pc_f_r + 32'd4;
                end else begin
                    resp_valid_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: streaming, stall hold, redirects, fetch enable drop,
// reset mid-stream and PC wrap, against a behavioural synchronous imem.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_stall;
    logic [31:0] imem_data = 32'd0;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] instr_cnt;
    logic [31:0] bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ifetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_stall     (imem_stall),
        .imem_data      (imem_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .instr_cnt      (instr_cnt),
        .bubble_cnt     (bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h5A00_0000 | {8'h00, a[23:0]};
    endfunction

    // Synchronous imem: data one cycle after address unless stalled
    always @(posedge clk) begin
        if (!imem_stall) imem_data <= mem_word(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, id_valid}, {31'd0, v});
        if (v) begin
            check({tag, "_pc"}, id_pc, pc);
            check({tag, "_instr"}, id_instr, mem_word(pc));
        end else begin
            check({tag, "_nop"}, id_instr, 32'h0000_0013);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; id_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        tick(); tick(); #1;
        chk_id("rst", 1'b0, 32'd0);
        check("rst_stall", {31'd0, imem_stall}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_icnt", instr_cnt, 32'd0);
        check("rst_bcnt", bubble_cnt, 32'd0);

        // Streaming from reset
        tick(); rst = 1'b0; fetch_en = 1'b1; #1;
        chk_id("c0", 1'b0, 32'd0);
        tick(); #1; chk_id("c1", 1'b0, 32'd0); check("c1_addr", imem_addr, 32'd0);
        tick(); #1; chk_id("c2", 1'b1, 32'h0); check("c2_icnt", instr_cnt, 32'd0);
        tick(); #1; chk_id("c3", 1'b1, 32'h4); check("c3_icnt", instr_cnt, 32'd1);

        // Three stall cycles at 0x8
        for (int i = 0; i < 3; i++) begin
            tick(); id_ready = 1'b0; #1;
            chk_id("stall", 1'b1, 32'h8);
            check("stall_sig", {31'd0, imem_stall}, 32'd1);
            check("stall_icnt", instr_cnt, 32'd2);
        end
        tick(); id_ready = 1'b1; #1;
        chk_id("c7", 1'b1, 32'h8); check("c7_stall", {31'd0, imem_stall}, 32'd0);
        tick(); #1; chk_id("c8", 1'b1, 32'hC); check("c8_icnt", instr_cnt, 32'd3);
        tick(); #1; chk_id("c9", 1'b1, 32'h10);

        // Redirect while streaming
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
        chk_id("rd_t", 1'b0, 32'd0); check("rd_t_icnt", instr_cnt, 32'd5);
        tick(); redirect_valid = 1'b0; #1; chk_id("rd_t1", 1'b0, 32'd0);
        tick(); #1; chk_id("rd_t2", 1'b1, 32'h100);
        check("rd_t2_icnt", instr_cnt, 32'd5); check("rd_t2_bcnt", bubble_cnt, 32'd3);
        tick(); #1; chk_id("c13", 1'b1, 32'h104);

        // Redirect while stalled
        tick(); id_ready = 1'b0; #1;
        chk_id("c14", 1'b1, 32'h108); check("c14_stall", {31'd0, imem_stall}, 32'd1);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        check("rds_stall", {31'd0, imem_stall}, 32'd0); chk_id("rds_t", 1'b0, 32'd0);
        tick(); redirect_valid = 1'b0; id_ready = 1'b1; #1; chk_id("rds_t1", 1'b0, 32'd0);
        tick(); #1; chk_id("rds_t2", 1'b1, 32'h200); check("rds_icnt", instr_cnt, 32'd7);

        // fetch_en drop with one response outstanding
        tick(); fetch_en = 1'b0; #1; chk_id("fe_last", 1'b1, 32'h204);
        tick(); #1; chk_id("fe_off1", 1'b0, 32'd0);
        check("fe_icnt", instr_cnt, 32'd9); check("fe_bcnt1", bubble_cnt, 32'd5);
        tick(); #1; chk_id("fe_off2", 1'b0, 32'd0); check("fe_bcnt2", bubble_cnt, 32'd5);
        tick(); fetch_en = 1'b1; #1; check("fe_bcnt3", bubble_cnt, 32'd5);
        tick(); #1; chk_id("fe_on1", 1'b0, 32'd0);
        tick(); #1; chk_id("fe_on2", 1'b1, 32'h208); check("fe_bcnt4", bubble_cnt, 32'd6);

        // Reset while stalled
        tick(); id_ready = 1'b0; #1; chk_id("c24", 1'b1, 32'h20C);
        tick(); rst = 1'b1; #1;
        tick(); rst = 1'b0; fetch_en = 1'b0; id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
        chk_id("rs", 1'b0, 32'd0);
        check("rs_addr", imem_addr, 32'd0);
        check("rs_icnt", instr_cnt, 32'd0);
        check("rs_bcnt", bubble_cnt, 32'd0);

        // Redirect with fetch_en=0, then PC wrap
        tick(); redirect_valid = 1'b0; fetch_en = 1'b1; #1;
        check("wr_addr", imem_addr, 32'hFFFF_FFFC); chk_id("wr_c27", 1'b0, 32'd0);
        tick(); #1; chk_id("wr_c28", 1'b0, 32'd0);
        tick(); #1; chk_id("wr_top", 1'b1, 32'hFFFF_FFFC);
        check("wr_addr0", imem_addr, 32'd0);
        tick(); #1; chk_id("wr_zero", 1'b1, 32'h0);
        check("wr_icnt", instr_cnt, 32'd1); check("wr_bcnt", bubble_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
